// File: rtl/program_flow_pkg.sv
// Shared opcode encoding, FSM states and width defaults for the UrCPU program-flow sequencer.
package program_flow_pkg;

    localparam int DEF_DATA_W      = 20;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_STACK_DEPTH = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JNZ  = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RET  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/return_stack.sv
// Parameterised LIFO holding return addresses; illegal push/pop are ignored here and
// reported by the controller.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] top_idx;

    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_idx  = PTR_W'(count_q - (PTR_W + 1)'(1));
    assign data_out = mem_q[top_idx];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + (PTR_W + 1)'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q alone defines
    // which entries are live, so the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[count_q[PTR_W-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/program_flow_ctrl.sv
// UrCPU program-flow sequencer: owns the PC, decodes flow opcodes, drives the return
// stack and announces taken redirects with a one-cycle flush.
module program_flow_ctrl
    import program_flow_pkg::*;
#(
    parameter int                 DATA_W      = DEF_DATA_W,
    parameter int                 ADDR_W      = DEF_ADDR_W,
    parameter int                 STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              halted,
    output logic              stack_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, halted_q, stack_err_q;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              accept;
    logic              redirect;
    logic              err_set;

    logic              stk_push, stk_pop;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    assign opcode = instr[DATA_W-1 -: 4];
    assign target = instr[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    // Ready depends only on state and stall so no path exists from instr_valid.
    assign instr_ready = (state_q == ST_RUN) && !stall;
    assign accept      = instr_valid && instr_ready;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_return_stack (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (pc_inc),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        redirect = 1'b0;
        err_set  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    pc_d = pc_inc;
                    case (opcode)
                        OP_JMP:  redirect = 1'b1;
                        OP_JZ:   redirect = zero_flag;
                        OP_JNZ:  redirect = !zero_flag;
                        OP_CALL: begin
                            if (stk_full) begin
                                err_set = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                                redirect = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                err_set = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                                state_d = ST_FLUSH;
                            end
                        end
                        OP_HALT: begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
                        default: ;
                    endcase
                    if (redirect) begin
                        pc_d    = target;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= (state_d == ST_FLUSH);
            halted_q    <= (state_d == ST_HALT);
            stack_err_q <= stack_err_q | err_set;
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign halted    = halted_q;
    assign stack_err = stack_err_q;

endmodule
